rdy_ack_pkt_tx: RTL
===================

Name: rdy_ack_pkt_tx

Overview:
- Packet transmitter on the team's rdy/ack streaming protocol (source asserts rdy with data; sink asserts ack; transfer on rdy & ack).
- Accepts a command (header word + payload length) and a payload word stream, then emits one framed packet: header word, then N payload words, with o_last on the final word.
- Sits on the producer side of an rdy/ack FIFO, driving its input port.

Parameters:
- DW_M1, 8, data/header width minus 1.
- LW_M1, 7, payload length field width minus 1 (max 2^(LW_M1+1)-1 payload words).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_rdy  in  1  command valid
- cmd_ack  out  1  command accepted
- cmd_hdr  in  DW_M1+1  header word for packet
- cmd_len  in  LW_M1+1  payload word count (0 = header-only packet)
- p_rdy  in  1  payload word valid
- p_ack  out  1  payload word accepted
- p_data  in  DW_M1+1  payload word
- o_rdy  out  1  output word valid
- o_ack  in  1  downstream accepts
- o_data  out  DW_M1+1  output word
- o_last  out  1  output word is final word of packet
- busy  out  1  packet in progress (state != IDLE or o_rdy)

Behaviour:
- Reset (async): state=IDLE, o_rdy=0, o_last=0, o_data=0, remaining count=0; cmd_ack=0 and p_ack=0 follow from state. Reset mid-packet discards the packet; no partial completion after release.
- Output register: single stage, o_rdy/o_data/o_last all registered. load = !o_rdy | o_ack. When load and a new word is captured, o_rdy<=1; when o_ack and nothing captured, o_rdy<=0; otherwise hold. o_data/o_last stable while o_rdy & !o_ack.
- cmd_ack = (state==IDLE) & load, combinational, independent of cmd_rdy. p_ack = (state==PAY) & load, independent of p_rdy. No ack in other states.
- States: IDLE, PAY.
  - IDLE: on cmd_rdy & cmd_ack, capture o_data<=cmd_hdr, o_last<=(cmd_len==0), remaining<=cmd_len; next state = PAY if cmd_len!=0, else IDLE.
  - PAY: on p_rdy & p_ack, capture o_data<=p_data, o_last<=(remaining==1), remaining<=remaining-1; if remaining==1, next state = IDLE.
- Latency: 1 cycle from accepted cmd/payload handshake to o_rdy=1 with that word.
- Throughput: with o_ack, cmd_rdy and p_rdy held high, one word per cycle, including back-to-back packets (no idle cycle between o_last and the next header).
- Backpressure: o_ack=0 while o_rdy=1 stalls both cmd_ack and p_ack; no word is lost or duplicated.
- Payload words are consumed only in PAY; p_rdy in IDLE is ignored (p_ack=0).
- Length arithmetic: unsigned LW_M1+1 bits; remaining never wraps because decrement only occurs while remaining >= 1.
- busy = (state!=IDLE) | o_rdy.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_PAY) and the rdy/ack load-condition convention.
- One natural sub-module, rdy_ack_out_reg: registered output stage with load/valid logic, parameterised by width (data + last). FSM and counter stay in the top module.

Test Plan:
- cmd_hdr=0xA5, cmd_len=3, payload 0x01,0x02,0x03 presented, o_ack=1 -> o_data sequence A5,01,02,03 on consecutive cycles; o_last=1 only on 03; busy drops the cycle after.
- cmd_len=0, cmd_hdr=0x3C -> single word 3C with o_last=1; cmd_ack reasserted next cycle; p_ack never asserted.
- Packet len=2, o_ack held 0 for 4 cycles after header -> o_data=header stable, o_rdy=1, p_ack=0 throughout; after release, words follow with none lost.
- Two commands back-to-back (len 1 and len 2), all rdy/ack high -> 5 output words in 5 consecutive cycles, o_last on words 2 and 5.
- p_rdy gapped (1 of every 3 cycles) for len=4 -> o_rdy drops during gaps, exactly 4 payload words emitted in order.
- rst_n asserted mid-payload (after 2 of 5 words) -> o_rdy=0, busy=0, state IDLE immediately; after release, a new command is sent cleanly with correct o_last.

Source files
------------

// File: rtl/rdy_ack_pkt_tx_pkg.sv
// Shared definitions for the rdy/ack packet transmitter: FSM state encoding
// and the rdy/ack output-stage load condition.
package rdy_ack_pkt_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PAY  = 1'b1
  } tx_state_e;

  // An output stage may take a new word when it is empty or is being drained.
  function automatic logic load_f(input logic rdy, input logic ack);
    return (~rdy) | ack;
  endfunction

endpackage

// File: rtl/rdy_ack_out_reg.sv
// Single-stage registered rdy/ack source: holds one word until accepted.
module rdy_ack_out_reg
  import rdy_ack_pkt_tx_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] d,
  input  logic         ack,
  output logic         rdy,
  output logic [W-1:0] q,
  output logic         load
);

  logic         rdy_r;
  logic [W-1:0] q_r;

  assign load = load_f(rdy_r, ack);
  assign rdy  = rdy_r;
  assign q    = q_r;

  // Capture a new word when allowed, otherwise drop valid once it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r <= 1'b0;
      q_r   <= '0;
    end else if (load && cap) begin
      rdy_r <= 1'b1;
      q_r   <= d;
    end else if (ack) begin
      rdy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rdy_ack_pkt_tx.sv
// Packet framer: emits a header word followed by cmd_len payload words on a
// rdy/ack stream, flagging the final word with o_last.
module rdy_ack_pkt_tx
  import rdy_ack_pkt_tx_pkg::*;
#(
  parameter int DW_M1 = 8,
  parameter int LW_M1 = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_rdy,
  output logic             cmd_ack,
  input  logic [DW_M1:0]   cmd_hdr,
  input  logic [LW_M1:0]   cmd_len,
  input  logic             p_rdy,
  output logic             p_ack,
  input  logic [DW_M1:0]   p_data,
  output logic             o_rdy,
  input  logic             o_ack,
  output logic [DW_M1:0]   o_data,
  output logic             o_last,
  output logic             busy
);

  localparam logic [LW_M1:0] LEN_ZERO = '0;
  localparam logic [LW_M1:0] LEN_ONE  = {{LW_M1{1'b0}}, 1'b1};

  tx_state_e         state_r, state_nx_s;
  logic [LW_M1:0]    rem_r, rem_nx_s;
  logic              cap_s;
  logic [DW_M1+1:0]  d_s;
  logic [DW_M1+1:0]  q_s;
  logic              load_s;

  assign cmd_ack = (state_r == ST_IDLE) && load_s;
  assign p_ack   = (state_r == ST_PAY) && load_s;
  assign o_data  = q_s[DW_M1:0];
  assign o_last  = q_s[DW_M1+1];
  assign busy    = (state_r != ST_IDLE) || o_rdy;

  // State and remaining-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rem_r   <= LEN_ZERO;
    end else begin
      state_r <= state_nx_s;
      rem_r   <= rem_nx_s;
    end
  end

  // Next-state, counter update and word selection for the output stage.
  always_comb begin
    state_nx_s = state_r;
    rem_nx_s   = rem_r;
    cap_s      = 1'b0;
    d_s        = '0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_rdy && cmd_ack) begin
          cap_s      = 1'b1;
          d_s        = {(cmd_len == LEN_ZERO), cmd_hdr};
          rem_nx_s   = cmd_len;
          state_nx_s = (cmd_len != LEN_ZERO) ? ST_PAY : ST_IDLE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PAY: begin
        // Only reachable with rem_r >= 1, so the decrement cannot wrap.
        if (p_rdy && p_ack) begin
          cap_s      = 1'b1;
          d_s        = {(rem_r == LEN_ONE), p_data};
          rem_nx_s   = rem_r - LEN_ONE;
          state_nx_s = (rem_r == LEN_ONE) ? ST_IDLE : ST_PAY;
        end else begin
          state_nx_s = ST_PAY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        rem_nx_s   = LEN_ZERO;
      end
    endcase
  end

  rdy_ack_out_reg #(
    .W(DW_M1 + 2)
  ) u_out_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .cap  (cap_s),
    .d    (d_s),
    .ack  (o_ack),
    .rdy  (o_rdy),
    .q    (q_s),
    .load (load_s)
  );

endmodule
